// File: rtl/fetch_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID register, obeys hazard-unit stalls,
// applies ID-stage redirects and primes the synchronous instruction memory after reset.
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int unsigned RST_STALL_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_pc,
    input  logic        i_stall_if_id,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    output logic        o_id_valid,
    output logic        o_rst_stall,
    output logic [31:0] o_stall_count,
    output logic [31:0] o_flush_count
);

    localparam logic [31:0] Nop     = 32'h0000_0013;
    localparam logic [3:0]  RstLoad = 4'(RST_STALL_CYCLES);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic ext_stall;
    logic rst_stall;
    logic redirect_take;

    assign ext_stall     = i_stall_pc | i_stall_if_id;
    assign rst_stall     = (rst_cnt_q != 4'd0);
    assign redirect_take = i_redirect & ~ext_stall & ~rst_stall;

    // Next PC doubles as the memory address so read data lines up with pc_q.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (!i_rst_n) begin
            pc_d = RESET_ADDR;
        end else if (rst_stall || ext_stall) begin
            pc_d = pc_q;
        end else if (i_redirect) begin
            pc_d = i_redirect_target & ~32'h0000_0003;
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (rst_stall) begin
            id_pc_d    = pc_q;
            id_inst_d  = Nop;
            id_valid_d = 1'b0;
        end else if (ext_stall) begin
            id_pc_d    = id_pc_q;
        end else if (i_redirect) begin
            // Squash the fall-through fetch currently sitting in IF.
            id_pc_d    = pc_q;
            id_inst_d  = Nop;
            id_valid_d = 1'b0;
        end else begin
            id_pc_d    = pc_q;
            id_inst_d  = i_imem_rdata;
            id_valid_d = 1'b1;
        end
    end

    always_comb begin
        rst_cnt_d   = rst_stall ? rst_cnt_q - 4'd1 : rst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ext_stall && !rst_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect_take && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        pc_q <= pc_d;
        if (!i_rst_n) begin
            id_pc_q     <= 32'd0;
            id_inst_q   <= Nop;
            id_valid_q  <= 1'b0;
            rst_cnt_q   <= RstLoad;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            rst_cnt_q   <= rst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_imem_addr   = pc_d;
    assign o_if_pc       = pc_q;
    assign o_id_pc       = id_pc_q;
    assign o_id_inst     = id_inst_q;
    assign o_id_valid    = id_valid_q;
    assign o_rst_stall   = rst_stall;
    assign o_stall_count = stall_cnt_q;
    assign o_flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver predicts each cycle from a behavioural model and a
// separate monitor compares the fetch address and the post-edge state against those predictions.
module tb_fetch_ctrl;

    localparam logic [31:0] RstAddr   = 32'h0000_0000;
    localparam int          RstCycles = 1;
    localparam logic [31:0] Nop       = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_pc;
    logic        stall_if_id;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        rst_stall;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    fetch_ctrl #(
        .RESET_ADDR       (RstAddr),
        .RST_STALL_CYCLES (RstCycles)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall_pc        (stall_pc),
        .i_stall_if_id     (stall_if_id),
        .i_redirect        (redirect),
        .i_redirect_target (target),
        .i_imem_rdata      (imem_rdata),
        .o_imem_addr       (imem_addr),
        .o_if_pc           (if_pc),
        .o_id_pc           (id_pc),
        .o_id_inst         (id_inst),
        .o_id_valid        (id_valid),
        .o_rst_stall       (rst_stall),
        .o_stall_count     (stall_count),
        .o_flush_count     (flush_count)
    );

    typedef struct packed {
        logic [31:0] if_pc;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        id_valid;
        logic        rst_stall;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } state_t;

    state_t      exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: program order as seen from the fetch side.
    logic [31:0] m_pc;
    int          m_rst_left;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit sp, input bit si, input bit rd,
                        input logic [31:0] t);
        logic [31:0] nxt;
        state_t      s;
        rst_n       = r;
        stall_pc    = sp;
        stall_if_id = si;
        redirect    = rd;
        target      = t;

        if (!r)                      nxt = RstAddr;
        else if (m_rst_left > 0)     nxt = m_pc;
        else if (sp || si)           nxt = m_pc;
        else if (rd)                 nxt = {t[31:2], 2'b00};
        else                         nxt = m_pc + 32'd4;
        addr_q.push_back(nxt);

        if (!r) begin
            m_id_pc    = 32'd0;
            m_id_inst  = Nop;
            m_id_valid = 1'b0;
            m_rst_left = RstCycles;
            m_stalls   = 32'd0;
            m_flushes  = 32'd0;
        end else if (m_rst_left > 0) begin
            m_id_pc    = m_pc;
            m_id_inst  = Nop;
            m_id_valid = 1'b0;
            m_rst_left = m_rst_left - 1;
        end else if (sp || si) begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        end else if (rd) begin
            m_id_pc    = m_pc;
            m_id_inst  = Nop;
            m_id_valid = 1'b0;
            if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
        end else begin
            m_id_pc    = m_pc;
            m_id_inst  = mem_word(m_pc);
            m_id_valid = 1'b1;
        end
        m_pc = nxt;

        s.if_pc     = m_pc;
        s.id_pc     = m_id_pc;
        s.id_inst   = m_id_inst;
        s.id_valid  = m_id_valid;
        s.rst_stall = (m_rst_left != 0);
        s.stall_cnt = m_stalls;
        s.flush_cnt = m_flushes;
        exp_q.push_back(s);

        @(posedge clk);
        #2;
    endtask

    task automatic check_addr();
        if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL addr_queue: got empty expected entry (t=%0t)", $time);
        end else begin
            check("imem_addr", imem_addr, addr_q.pop_front());
        end
    endtask

    task automatic check_state();
        state_t s;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL state_queue: got empty expected entry (t=%0t)", $time);
        end else begin
            s = exp_q.pop_front();
            check("if_pc", if_pc, s.if_pc);
            check("id_pc", id_pc, s.id_pc);
            check("id_inst", id_inst, s.id_inst);
            check("id_valid", 32'(id_valid), 32'(s.id_valid));
            check("rst_stall", 32'(rst_stall), 32'(s.rst_stall));
            check("stall_count", stall_count, s.stall_cnt);
            check("flush_count", flush_count, s.flush_cnt);
        end
    endtask

    // Monitor: address checked mid-cycle, registered state just after each edge.
    initial begin
        #3;
        check_addr();
        forever begin
            @(posedge clk);
            #1;
            check_state();
            @(negedge clk);
            check_addr();
        end
    end

    initial begin
        m_pc = RstAddr;
        m_rst_left = RstCycles;
        m_id_pc = 32'd0;
        m_id_inst = Nop;
        m_id_valid = 1'b0;
        m_stalls = 32'd0;
        m_flushes = 32'd0;

        repeat (2) step(0, 0, 0, 0, 32'd0);
        repeat (4) step(1, 0, 0, 0, 32'd0);
        repeat (2) step(1, 1, 1, 0, 32'd0);
        repeat (3) step(1, 0, 0, 0, 32'd0);
        step(1, 0, 0, 1, 32'h0000_0103);
        repeat (2) step(1, 0, 0, 0, 32'd0);
        step(1, 1, 0, 1, 32'h0000_0200);
        step(1, 0, 0, 1, 32'h0000_0200);
        repeat (2) step(1, 0, 0, 0, 32'd0);
        step(1, 0, 0, 1, 32'hFFFF_FFFF);
        repeat (2) step(1, 0, 0, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        repeat (4) step(1, 0, 0, 0, 32'd0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(59) != 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(3) == 0),
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
